// File: rtl/cpu_pc_pkg.sv
// Shared types and constants for the program-counter update stage.
package cpu_pc_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_00FC;

  localparam int unsigned SRC_MDR    = 0;
  localparam int unsigned SRC_ALU    = 1;
  localparam int unsigned SRC_ALUOUT = 2;
  localparam int unsigned SRC_CONCAT = 3;
  localparam int unsigned SRC_EPC    = 4;

endpackage

// File: rtl/pc_update_unit_if.sv
// Control/datapath bundle between the control unit and the PC stage.
interface pc_update_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic                     pc_write;
  logic                     pc_write_cond;
  logic                     cond_flag;
  logic                     stall;
  logic                     exc_ack;
  logic [WIDTH-1:0]         pc_out;
  logic [WIDTH-1:0]         pc_next;
  logic                     misalign_exc;
  logic [WIDTH-1:0]         bad_addr;
  logic                     sel_err;
  logic                     in_trap;
  logic [CNT_W-1:0]         upd_count;

  modport master (
    output sel, src_data, pc_write, pc_write_cond, cond_flag, stall, exc_ack,
    input  pc_out, pc_next, misalign_exc, bad_addr, sel_err, in_trap, upd_count
  );

  modport slave (
    input  sel, src_data, pc_write, pc_write_cond, cond_flag, stall, exc_ack,
    output pc_out, pc_next, misalign_exc, bad_addr, sel_err, in_trap, upd_count
  );
endinterface

// File: rtl/pc_src_mux.sv
// Flattened-bus source selector; out-of-range select falls back to a given value.
module pc_src_mux #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 5
) (
  input  logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] sel,
  input  logic [NUM_SRC*WIDTH-1:0]                          src_data,
  input  logic [WIDTH-1:0]                                  fallback,
  output logic [WIDTH-1:0]                                  data_c,
  output logic                                              sel_ok_c
);

  // Pick src_data[sel]; flag whether sel named a real source.
  always_comb begin
    data_c   = fallback;
    sel_ok_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (32'(sel) == i) begin
        data_c   = src_data[i*WIDTH +: WIDTH];
        sel_ok_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_update_unit.sv
// Registered PC stage: source select, write enables, alignment trap, load counter.
module pc_update_unit
  import cpu_pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      NUM_SRC    = 5,
  parameter int unsigned      ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] TRAP_VEC   = WIDTH'(DEF_TRAP_VEC),
  parameter int unsigned      CNT_W      = 16
) (
  input logic          clk,
  input logic          rst_n,
  pc_update_if.slave   bus
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'(1) << ALIGN_BITS) - 64'(1));

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] bad_addr_q, bad_addr_d;
  logic             misalign_q, misalign_d;
  logic             sel_err_q, sel_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] pc_next_c;
  logic             sel_ok_c;
  logic             req_c;
  logic             en_c;
  logic             misaligned_c;
  logic             load_c;

  pc_src_mux #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC)
  ) u_src_mux (
    .sel      (bus.sel),
    .src_data (bus.src_data),
    .fallback (pc_q),
    .data_c   (pc_next_c),
    .sel_ok_c (sel_ok_c)
  );

  assign req_c        = bus.pc_write | (bus.pc_write_cond & bus.cond_flag);
  assign en_c         = req_c & ~bus.stall & (state_q == ST_RUN);
  assign misaligned_c = |(pc_next_c & ALIGN_MASK);

  // Next-state, PC load, trap capture and saturating load counter.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    bad_addr_d = bad_addr_q;
    misalign_d = 1'b0;
    sel_err_d  = 1'b0;
    cnt_d      = cnt_q;
    load_c     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (en_c) begin
          if (!sel_ok_c) begin
            sel_err_d = 1'b1;
          end else if (misaligned_c) begin
            pc_d       = TRAP_VEC;
            bad_addr_d = pc_next_c;
            misalign_d = 1'b1;
            state_d    = ST_TRAP;
            load_c     = 1'b1;
          end else begin
            pc_d   = pc_next_c;
            load_c = 1'b1;
          end
        end
      end
      ST_TRAP: begin
        if (bus.exc_ack) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (load_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VEC;
      bad_addr_q <= '0;
      misalign_q <= 1'b0;
      sel_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      bad_addr_q <= bad_addr_d;
      misalign_q <= misalign_d;
      sel_err_q  <= sel_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.pc_next      = pc_next_c;
  assign bus.misalign_exc = misalign_q;
  assign bus.bad_addr     = bad_addr_q;
  assign bus.sel_err      = sel_err_q;
  assign bus.in_trap      = (state_q == ST_TRAP);
  assign bus.upd_count    = cnt_q;

endmodule
